// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin share of one SPI master engine between NREQ requesters
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   req             per-requester level request, held until ack
//   req_slv         2-bit slave index per requester, {r[N-1],...,r[0]}
//   req_data        DW-bit tx word per requester, same packing
//   gnt             one-hot current owner of the SPI master
//   ack             one-cycle pulse to the owner at end of transfer
//   err             one-cycle pulse with ack when the transfer timed out
//   rx_data         last received word, valid in the ack cycle and held
//   m_start         one-cycle start pulse to the SPI master
//   m_tx            tx word to the master, stable while gnt != 0
//   m_done, m_rx    master completion pulse and received word
//   ss_n            active-low slave selects, at most one low
module spi_xfer_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 64,
   parameter int GAP_CYC = 2
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    req_slv,
   input  logic [DW*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      ack,
   output logic                 err,
   output logic [DW-1:0]        rx_data,
   output logic                 m_start,
   output logic [DW-1:0]        m_tx,
   input  logic                 m_done,
   input  logic [DW-1:0]        m_rx,
   output logic [3:0]           ss_n
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = $clog2(TIMEOUT);
   localparam int GW = $clog2(GAP_CYC + 1);
   typedef enum logic [1:0] {S_IDLE, S_SEL, S_WAIT, S_GAP} state_t;
   state_t        state;
   logic [IW-1:0] ptr, win, j;
   logic [WW-1:0] wd;
   logic [GW-1:0] gcnt;
   // Descending scan so the last hit, i.e. the one nearest ptr+1, wins.
   always_comb begin
      win = ptr;
      j   = '0;
      for (int i = NREQ; i >= 1; i--) begin
         j = IW'((int'(ptr) + i) % NREQ);
         if (req[j]) win = j;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ptr     <= IW'(NREQ - 1);
         gnt     <= '0;
         ack     <= '0;
         err     <= 1'b0;
         rx_data <= '0;
         m_start <= 1'b0;
         m_tx    <= '0;
         ss_n    <= 4'hF;
         wd      <= '0;
         gcnt    <= '0;
      end else begin
         ack     <= '0;
         err     <= 1'b0;
         m_start <= 1'b0;
         case (state)
            S_IDLE: if (|req) begin
               ptr     <= win;
               gnt     <= NREQ'(1) << win;
               m_tx    <= req_data[DW*win +: DW];
               ss_n    <= ~(4'b0001 << req_slv[2*win +: 2]);
               m_start <= 1'b1;
               state   <= S_SEL;
            end
            S_SEL: begin
               wd    <= '0;
               state <= S_WAIT;
            end
            // A done arriving on the watchdog's last cycle still counts as success.
            S_WAIT: if (m_done || wd == WW'(TIMEOUT - 1)) begin
               ack   <= gnt;
               err   <= !m_done;
               if (m_done) rx_data <= m_rx;
               gnt   <= '0;
               ss_n  <= 4'hF;
               gcnt  <= '0;
               state <= S_GAP;
            end else wd <= wd + 1'b1;
            S_GAP: if (gcnt == GW'(GAP_CYC - 1)) state <= S_IDLE;
                   else gcnt <= gcnt + 1'b1;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed self-checking bench for spi_xfer_arbiter
module tb_spi_xfer_arbiter;
   localparam int TIMEOUT = 64;
   logic        clk, rst_n, m_done, err, m_start;
   logic [3:0]  req, gnt, ack, ss_n;
   logic [7:0]  req_slv;
   logic [31:0] req_data;
   logic [7:0]  rx_data, m_tx, m_rx;
   logic [1:0]  slv_t [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
   logic [7:0]  dat_t [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
   logic [7:0]  last_rx;
   int checks = 0, errors = 0;

   spi_xfer_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(TIMEOUT), .GAP_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_slv(req_slv), .req_data(req_data),
      .gnt(gnt), .ack(ack), .err(err), .rx_data(rx_data), .m_start(m_start),
      .m_tx(m_tx), .m_done(m_done), .m_rx(m_rx), .ss_n(ss_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle with req already set; returns in the next IDLE cycle.
   // lat==0 means the master never answers (timeout path).
   task automatic xfer(input int w, input int lat, input logic [7:0] rxv, input bit drop);
      logic [3:0] sel;
      logic [7:0] exp_rx;
      bit to;
      to  = (lat == 0);
      sel = ~(4'b0001 << slv_t[w]);
      tick;
      chk("grant_gnt", gnt, 32'(1 << w));
      chk("grant_ss_n", ss_n, sel);
      chk("grant_m_tx", m_tx, dat_t[w]);
      chk("grant_m_start", m_start, 1);
      chk("grant_ack", ack, 0);
      if (drop) req[w] = 1'b0;
      tick;
      chk("sel_m_start", m_start, 0);
      chk("sel_ss_n", ss_n, sel);
      if (to) begin
         repeat (TIMEOUT - 1) tick;
         chk("to_early_ack", ack, 0);
         chk("to_hold_ss_n", ss_n, sel);
         tick;
      end else begin
         repeat (lat - 2) tick;
         m_done = 1'b1;
         m_rx   = rxv;
         tick;
         m_done = 1'b0;
      end
      exp_rx  = to ? last_rx : rxv;
      last_rx = exp_rx;
      chk("end_ack", ack, 32'(1 << w));
      chk("end_err", err, to);
      chk("end_rx", rx_data, exp_rx);
      chk("end_gnt", gnt, 0);
      chk("end_ss_n", ss_n, 4'hF);
      m_done = 1'b1;
      m_rx   = 8'h5A;
      tick;
      m_done = 1'b0;
      chk("gap_ack", ack, 0);
      chk("gap_err", err, 0);
      chk("gap_rx_stray", rx_data, exp_rx);
      chk("gap_ss_n", ss_n, 4'hF);
      tick;
      chk("gap2_ss_n", ss_n, 4'hF);
      chk("gap2_gnt", gnt, 0);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; m_done = 1'b0; m_rx = '0; last_rx = '0;
      for (int i = 0; i < 4; i++) begin
         req_slv[2*i +: 2]  = slv_t[i];
         req_data[8*i +: 8] = dat_t[i];
      end
      // reset
      repeat (3) tick;
      chk("rst_ss_n", ss_n, 4'hF);
      chk("rst_gnt", gnt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_m_start", m_start, 0);
      chk("rst_err", err, 0);
      chk("rst_rx", rx_data, 0);
      chk("rst_m_tx", m_tx, 0);
      rst_n = 1'b1;
      repeat (3) tick;
      chk("idle_ss_n", ss_n, 4'hF);
      chk("idle_gnt", gnt, 0);
      chk("idle_m_start", m_start, 0);
      // single transfer
      req = 4'b0001;
      xfer(0, 8, 8'h3C, 0);
      req = 4'b0000;
      // round robin from a fresh pointer
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      last_rx = '0;
      req = 4'b1111;
      xfer(0, 3, 8'h10, 0);
      xfer(1, 4, 8'h21, 0);
      xfer(2, 5, 8'h32, 0);
      xfer(3, 6, 8'h43, 0);
      xfer(0, 3, 8'h54, 0);
      // timeout, then a normal transfer
      req = 4'b0010;
      xfer(1, 0, 8'h00, 0);
      req = 4'b0100;
      xfer(2, 4, 8'h77, 0);
      // done on the timeout cycle
      req = 4'b1000;
      xfer(3, TIMEOUT + 1, 8'h88, 0);
      // req dropped during the transfer
      req = 4'b0001;
      xfer(0, 5, 8'h99, 1);
      chk("drop_req_cleared", req, 0);
      // stray done in IDLE
      m_done = 1'b1;
      m_rx   = 8'h5A;
      tick;
      m_done = 1'b0;
      chk("idle_stray_ack", ack, 0);
      chk("idle_stray_rx", rx_data, 8'h99);
      chk("idle_stray_gnt", gnt, 0);
      chk("idle_stray_m_start", m_start, 0);
      // reset mid-WAIT
      req = 4'b0100;
      tick;
      chk("mid_gnt", gnt, 4'b0100);
      repeat (3) tick;
      chk("mid_ss_n", ss_n, 4'b0111);
      rst_n = 1'b0;
      tick;
      chk("midrst_ss_n", ss_n, 4'hF);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_ack", ack, 0);
      chk("midrst_m_start", m_start, 0);
      chk("midrst_rx", rx_data, 0);
      rst_n = 1'b1;
      last_rx = '0;
      req = 4'b1010;
      xfer(1, 3, 8'h42, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
